// File: rtl/mmio_tohost_port_if.sv
// rtl/mmio_tohost_port_if.sv - host drain channel (valid/ready/data) between the tohost FIFO and its consumer
interface mmio_tohost_port_if;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_ready;

    modport master (
        output host_valid,
        output host_data,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_data,
        output host_ready
    );
endinterface

// File: rtl/mmio_tohost_port.sv
// rtl/mmio_tohost_port.sv - MEM-stage tohost MMIO port: store decode, drain FIFO, sticky halt; macro MMIO_STATUS_READBACK_EN enables STATUS readback
module mmio_tohost_port #(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter logic [31:0] STATUS_ADDR = 32'h0000_1004,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_MemWrite,
    input  logic        mem_MemRead,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    output logic        mmio_hit,
    output logic [31:0] mmio_read_data,
    output logic        mmio_stall,
    output logic        halt,
    output logic [30:0] exit_code,
    mmio_tohost_port_if.master host
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic              halt_q,      halt_d;
    logic [30:0]       exit_code_q, exit_code_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];

    logic        hit_tohost;
    logic        hit_status;
    logic        tohost_store;
    logic        halt_req;
    logic        push_req;
    logic        push_ok;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [31:0] push_word;

    assign hit_tohost   = (mem_address == TOHOST_ADDR);
    assign hit_status   = (mem_address == STATUS_ADDR);
    assign mmio_hit     = (hit_tohost | hit_status) & (mem_MemWrite | mem_MemRead);

    // Only stores in RUN do anything; once halted the port is inert apart from draining.
    assign tohost_store = mem_MemWrite & hit_tohost & (state_q == ST_RUN);
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign pop          = host.host_valid & host.host_ready;
    // A pop in the same cycle frees the slot the push needs, so a full FIFO can still accept.
    assign push_ok      = ~full | pop;
    assign mmio_stall   = push_req & ~push_ok;
    assign push         = push_req & push_ok;

    // Classify the TOHOST store: exit word, pushable word, or ignored size.
    always_comb begin
        halt_req  = 1'b0;
        push_req  = 1'b0;
        push_word = 32'h0;
        if (tohost_store) begin
            case (mem_funct3)
                F3_SB: begin
                    push_req  = 1'b1;
                    push_word = {24'h0, mem_write_data[7:0]};
                end
                F3_SH: begin
                    push_req  = 1'b1;
                    push_word = {16'h0, mem_write_data[15:0]};
                end
                F3_SW: begin
                    if (mem_write_data[0]) begin
                        halt_req = 1'b1;
                    end else begin
                        push_req  = 1'b1;
                        push_word = mem_write_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state for the run/halt FSM and the FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        halt_d      = halt_q;
        exit_code_d = exit_code_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (halt_req) begin
            state_d     = ST_HALTED;
            halt_d      = 1'b1;
            exit_code_d = mem_write_data[31:1];
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards queued entries by clearing pointers and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            halt_q      <= 1'b0;
            exit_code_q <= 31'h0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= halt_d;
            exit_code_q <= exit_code_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage is data-only and needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign host.host_valid = ~empty;
    assign host.host_data  = empty ? 32'h0 : fifo_mem_q[rd_ptr_q];
    assign halt            = halt_q;
    assign exit_code       = exit_code_q;

`ifdef MMIO_STATUS_READBACK_EN
    logic [31:0] status_word;
    assign status_word    = {16'h0, 13'(count_q), halt_q, full, empty};
    assign mmio_read_data = (mem_MemRead & hit_status) ? status_word : 32'h0;
`else
    assign mmio_read_data = 32'h0;
`endif

endmodule

// File: tb/tb_mmio_tohost_port.sv
// tb/tb_mmio_tohost_port.sv - scoreboard bench for mmio_tohost_port with directed cases and random traffic
module tb_mmio_tohost_port;

    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam logic [31:0] STATUS = 32'h0000_1004;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_MemWrite = 1'b0;
    logic        mem_MemRead = 1'b0;
    logic [2:0]  mem_funct3 = 3'b000;
    logic [31:0] mem_address = 32'h0;
    logic [31:0] mem_write_data = 32'h0;
    logic        mmio_hit;
    logic [31:0] mmio_read_data;
    logic        mmio_stall;
    logic        halt;
    logic [30:0] exit_code;

    mmio_tohost_port_if hif ();

    mmio_tohost_port #(
        .TOHOST_ADDR(TOHOST),
        .STATUS_ADDR(STATUS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_funct3    (mem_funct3),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mmio_hit      (mmio_hit),
        .mmio_read_data(mmio_read_data),
        .mmio_stall    (mmio_stall),
        .halt          (halt),
        .exit_code     (exit_code),
        .host          (hif.master)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic        pend_push = 1'b0;
    logic [31:0] pend_word = 32'h0;
    logic        pend_halt = 1'b0;
    logic [30:0] pend_exit = 31'h0;
    logic        m_halt = 1'b0;
    logic [30:0] m_exit = 31'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_model();
        int c;
        logic [31:0] w;
        c = exp_q.size();
`ifdef MMIO_STATUS_READBACK_EN
        w = {16'h0, 13'(c), m_halt, (c == DEPTH), (c == 0)};
`else
        w = 32'h0;
`endif
        return w;
    endfunction

    // Monitor: compares the drain channel against the scoreboard head away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("host_valid", {31'h0, hif.host_valid}, {31'h0, (exp_q.size() > 0)});
                if (exp_q.size() > 0) begin
                    chk("host_data", hif.host_data, exp_q[0]);
                    if (hif.host_ready) void'(exp_q.pop_front());
                end else begin
                    chk("host_data_empty", hif.host_data, 32'h0);
                end
            end
        end
    end

    // One clock of stimulus; the model decides what the port should do with this request.
    task automatic step(input logic rdy, input logic we, input logic re, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, output logic stalled);
        logic req;
        logic hlt;
        logic pop;
        logic exp_stall;
        logic [31:0] word;
        @(posedge clk);
        if (pend_push) begin
            exp_q.push_back(pend_word);
            pend_push = 1'b0;
        end
        if (pend_halt) begin
            m_halt    = 1'b1;
            m_exit    = pend_exit;
            pend_halt = 1'b0;
        end
        #1;
        hif.host_ready = rdy;
        mem_MemWrite   = we;
        mem_MemRead    = re;
        mem_funct3     = f3;
        mem_address    = a;
        mem_write_data = d;
        #2;
        word = 32'h0;
        hlt  = we && (a == TOHOST) && !m_halt && (f3 == 3'd2) && d[0];
        req  = 1'b0;
        if (we && (a == TOHOST) && !m_halt) begin
            if (f3 == 3'd0)               begin req = 1'b1; word = d & 32'hFF;   end
            else if (f3 == 3'd1)          begin req = 1'b1; word = d & 32'hFFFF; end
            else if (f3 == 3'd2 && !d[0]) begin req = 1'b1; word = d;            end
        end
        pop       = (exp_q.size() > 0) && rdy;
        exp_stall = req && (exp_q.size() == DEPTH) && !pop;
        chk("mmio_stall", {31'h0, mmio_stall}, {31'h0, exp_stall});
        chk("mmio_hit", {31'h0, mmio_hit},
            {31'h0, ((a == TOHOST) || (a == STATUS)) && (we || re)});
        chk("halt", {31'h0, halt}, {31'h0, m_halt});
        chk("exit_code", {1'b0, exit_code}, {1'b0, m_exit});
        if (re) chk("mmio_read_data", mmio_read_data, (a == STATUS) ? status_model() : 32'h0);
        if (req && !exp_stall) begin
            pend_push = 1'b1;
            pend_word = word;
        end
        if (hlt) begin
            pend_halt = 1'b1;
            pend_exit = d[31:1];
        end
        stalled = exp_stall;
    endtask

    task automatic idle(input logic rdy, input int n);
        logic st;
        for (int i = 0; i < n; i++) step(rdy, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, st);
    endtask

    // A store held in EX/MEM retries until accepted, as the pipeline would.
    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input int rdy_pct, output int nstall);
        logic st;
        nstall = 0;
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(99) < rdy_pct), 1'b1, 1'b0, f3, a, d, st);
            if (!st) return;
            nstall++;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL store_retry_bound: got %0d stalls expected fewer than 200", nstall);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset          = 1'b1;
        mem_MemWrite   = 1'b0;
        mem_MemRead    = 1'b0;
        hif.host_ready = 1'b0;
        exp_q.delete();
        pend_push = 1'b0;
        pend_halt = 1'b0;
        m_halt    = 1'b0;
        m_exit    = 31'h0;
        #1;
        chk("rst_host_valid", {31'h0, hif.host_valid}, 32'h0);
        chk("rst_host_data", hif.host_data, 32'h0);
        chk("rst_halt", {31'h0, halt}, 32'h0);
        chk("rst_exit_code", {1'b0, exit_code}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int ns;
        logic st;
        hif.host_ready = 1'b0;
        #2;
        do_reset();

        // 1: single word with a ready consumer
        store(3'd2, TOHOST, 32'h42, 100, ns);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, st);
        chk("t1_valid", {31'h0, hif.host_valid}, 32'h1);
        chk("t1_data", hif.host_data, 32'h42);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, st);
        chk("t1_valid_drop", {31'h0, hif.host_valid}, 32'h0);
        chk("t1_halt", {31'h0, halt}, 32'h0);

        // 2/3: fill with no consumer, 5th store stalls, then push+pop on full
        for (int i = 0; i < 4; i++) begin
            store(3'd2, TOHOST, 32'h100 + 32'(i * 2), 0, ns);
            chk("t2_accept_stalls", ns, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 3'd2, TOHOST, 32'h200, st);
            chk("t2_stall_full", {31'h0, mmio_stall}, 32'h1);
        end
        step(1'b1, 1'b1, 1'b0, 3'd2, TOHOST, 32'h200, st);
        chk("t3_stall_on_pop", {31'h0, mmio_stall}, 32'h0);
        step(1'b0, 1'b0, 1'b1, 3'd2, STATUS, 32'h0, st);
        chk("t3_still_full", {31'h0, hif.host_valid}, 32'h1);
        chk("t3_head", hif.host_data, 32'h102);
        idle(1'b1, 7);

        // 4: byte and halfword zero-extension
        store(3'd0, TOHOST, 32'hDEADBEEF, 0, ns);
        store(3'd1, TOHOST, 32'hDEADBEEF, 0, ns);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, st);
        chk("t4_sb", hif.host_data, 32'h0000_00EF);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, st);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, st);
        chk("t4_sh", hif.host_data, 32'h0000_BEEF);
        idle(1'b1, 2);

        // 6: status readback with two queued entries
        store(3'd2, TOHOST, 32'h11110, 0, ns);
        store(3'd2, TOHOST, 32'h22220, 0, ns);
        step(1'b0, 1'b0, 1'b1, 3'd2, STATUS, 32'h0, st);
        chk("t6_hit", {31'h0, mmio_hit}, 32'h1);
`ifdef MMIO_STATUS_READBACK_EN
        chk("t6_status", mmio_read_data, 32'h0000_0010);
`else
        chk("t6_status", mmio_read_data, 32'h0);
`endif
        step(1'b0, 1'b0, 1'b1, 3'd2, TOHOST, 32'h0, st);
        chk("t6_tohost_load", mmio_read_data, 32'h0);

        // 5: halt with exit code, later store dropped, reset clears everything
        store(3'd2, TOHOST, 32'h7, 0, ns);
        step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, st);
        chk("t5_halt", {31'h0, halt}, 32'h1);
        chk("t5_exit", {1'b0, exit_code}, 32'h3);
        step(1'b0, 1'b1, 1'b0, 3'd2, TOHOST, 32'h10, st);
        chk("t5_no_stall_halted", {31'h0, mmio_stall}, 32'h0);
        idle(1'b1, 1);
        do_reset();
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, st);
        chk("t5_reset_empty", {31'h0, hif.host_valid}, 32'h0);

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            int op;
            logic [31:0] d;
            op = int'($urandom_range(99));
            d  = $urandom;
            if (op < 30)      store(3'd2, TOHOST, d & ~32'h1, 50, ns);
            else if (op < 45) store(3'd0, TOHOST, d, 50, ns);
            else if (op < 60) store(3'd1, TOHOST, d, 50, ns);
            else if (op < 65) store(3'($urandom_range(7, 3)), TOHOST, d, 50, ns);
            else if (op < 70) store(3'd2, STATUS, d, 50, ns);
            else if (op < 75) store(3'd2, TOHOST ^ (32'h1 << $urandom_range(31)), d, 50, ns);
            else if (op < 85) step($urandom_range(1) == 1, 1'b0, 1'b1, 3'd2,
                                   ($urandom_range(1) == 1) ? STATUS : TOHOST, 32'h0, st);
            else if (op < 88) store(3'd2, TOHOST, d | 32'h1, 50, ns);
            else              idle($urandom_range(1) == 1, int'($urandom_range(3, 1)));
            if (m_halt && ($urandom_range(9) == 0)) do_reset();
        end
        idle(1'b1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
